// File: rtl/k12_alu_exec_pkg.sv
// Shared K12 constants, ALU opcode encoding and the EX-stage request bundle.
package k12_alu_exec_pkg;
  localparam int K12_DWIDTH = 8;
  localparam int K12_NREGS  = 8;
  localparam int K12_RIDX_W = $clog2(K12_NREGS);
  localparam int K12_INST_W = 16;

  // Opcode lives in inst[15:12]; inst[11:0] carries immediates.
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_MOV  = 4'h7,
    OP_LDI  = 4'h8,
    OP_CEQ  = 4'h9,
    OP_CLT  = 4'hA,
    OP_CLTS = 4'hB
  } k12_op_e;

  typedef struct packed {
    logic [K12_RIDX_W-1:0] rd;
    logic                  wb;
    logic                  pred;
    logic [K12_INST_W-1:0] inst;
  } k12_req_t;
endpackage

// File: rtl/k12_alu_exec_if.sv
// Decode->EX request handshake and EX->consumer retire handshake.
interface k12_alu_exec_if;
  import k12_alu_exec_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [K12_RIDX_W-1:0] in_rd;
  logic [K12_RIDX_W-1:0] in_rs;
  logic                  in_wb;
  logic                  in_pred;
  logic [K12_INST_W-1:0] in_inst;
  logic                  out_valid;
  logic                  out_ready;
  logic [K12_DWIDTH-1:0] out_res;
  logic                  out_cond;
  logic                  out_squash;

  modport slave (
    input  in_valid, in_rd, in_rs, in_wb, in_pred, in_inst, out_ready,
    output in_ready, out_valid, out_res, out_cond, out_squash
  );

  modport master (
    output in_valid, in_rd, in_rs, in_wb, in_pred, in_inst, out_ready,
    input  in_ready, out_valid, out_res, out_cond, out_squash
  );
endinterface

// File: rtl/k12_alu_exec_alu.sv
// k12_alu: combinational 8-bit ALU; res plus one condition bit per opcode.
module k12_alu
  import k12_alu_exec_pkg::*;
(
  input  logic [K12_INST_W-1:0] inst,
  input  logic [K12_DWIDTH-1:0] a,
  input  logic [K12_DWIDTH-1:0] b,
  output logic [K12_DWIDTH-1:0] res,
  output logic                  cond
);
  k12_op_e  w_op;
  logic [2:0] w_sh;

  assign w_op = k12_op_e'(inst[15:12]);
  // inst[11] selects an immediate shift amount in inst[10:8] instead of b[2:0]
  assign w_sh = inst[11] ? inst[10:8] : b[2:0];

  always_comb begin
    res  = '0;
    cond = 1'b0;
    case (w_op)
      OP_ADD:  {cond, res} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {cond, res} = {1'b0, a} - {1'b0, b};
      OP_AND:  begin res = a & b;      cond = ~|res; end
      OP_OR:   begin res = a | b;      cond = ~|res; end
      OP_XOR:  begin res = a ^ b;      cond = ~|res; end
      OP_SHL:  begin res = a << w_sh;  cond = ~|res; end
      OP_SHR:  begin res = a >> w_sh;  cond = ~|res; end
      OP_MOV:  begin res = b;          cond = ~|res; end
      OP_LDI:  begin res = inst[K12_DWIDTH-1:0]; cond = ~|res; end
      OP_CEQ:  begin res = a; cond = (a == b); end
      OP_CLT:  begin res = a; cond = (a < b); end
      OP_CLTS: begin res = a; cond = ($signed(a) < $signed(b)); end
      default: begin res = '0; cond = 1'b0; end
    endcase
  end
endmodule

// File: rtl/k12_alu_exec.sv
// K12 execute/write-back stage: one EX slot, 8x8 register file with retire bypass, cond flag.
module k12_alu_exec
  import k12_alu_exec_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  k12_alu_exec_if.slave         bus,
  output logic                  cond_flag,
  input  logic [K12_RIDX_W-1:0] dbg_idx,
  output logic [K12_DWIDTH-1:0] dbg_data
);
  logic [K12_NREGS-1:0][K12_DWIDTH-1:0] r_regs;
  logic                  r_ex_valid;
  k12_req_t              r_ex;
  logic [K12_DWIDTH-1:0] r_ex_a;
  logic [K12_DWIDTH-1:0] r_ex_b;
  logic                  r_cond_flag;

  logic                  w_out_fire;
  logic                  w_in_fire;
  logic                  w_squash;
  logic                  w_wr;
  logic [K12_DWIDTH-1:0] w_res;
  logic                  w_cond;
  logic [K12_DWIDTH-1:0] w_op_a;
  logic [K12_DWIDTH-1:0] w_op_b;

  k12_alu u_alu (
    .inst (r_ex.inst),
    .a    (r_ex_a),
    .b    (r_ex_b),
    .res  (w_res),
    .cond (w_cond)
  );

  assign w_squash   = r_ex.pred & ~r_cond_flag;
  assign w_out_fire = r_ex_valid & bus.out_ready;
  assign w_wr       = w_out_fire & ~w_squash & r_ex.wb;
  assign bus.in_ready = ~r_ex_valid | w_out_fire;
  assign w_in_fire  = bus.in_valid & bus.in_ready;

  assign bus.out_valid  = r_ex_valid;
  assign bus.out_res    = w_res;
  assign bus.out_cond   = w_cond;
  assign bus.out_squash = w_squash;
  assign cond_flag      = r_cond_flag;
  assign dbg_data       = r_regs[dbg_idx];

  // A retire writing the register being read this same edge must win over the stale copy
  assign w_op_a = (w_wr && r_ex.rd == bus.in_rd) ? w_res : r_regs[bus.in_rd];
  assign w_op_b = (w_wr && r_ex.rd == bus.in_rs) ? w_res : r_regs[bus.in_rs];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < K12_NREGS; i++)
        if (w_wr && r_ex.rd == K12_RIDX_W'(i)) r_regs[i] <= w_res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cond_flag <= 1'b0;
    end else if (w_out_fire && !w_squash) begin
      r_cond_flag <= w_cond;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_ex       <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
    end else if (w_in_fire) begin
      r_ex_valid <= 1'b1;
      r_ex.rd    <= bus.in_rd;
      r_ex.wb    <= bus.in_wb;
      r_ex.pred  <= bus.in_pred;
      r_ex.inst  <= bus.in_inst;
      r_ex_a     <= w_op_a;
      r_ex_b     <= w_op_b;
    end else if (w_out_fire) begin
      r_ex_valid <= 1'b0;
    end
  end
endmodule
